// File: rtl/mac_operand_fifo.sv
// mac_operand_fifo: DEPTH-entry valid/ready FIFO of (A, B) operand pairs feeding the MAC stage.
// Head operands read as zero whenever the FIFO is empty, so a stalled MAC sees cleared inputs.
module mac_operand_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]      wp;
    logic [AW-1:0]      rp;
    logic [CW-1:0]      count_q;
    logic               push;
    logic               pop;
    logic [2*WIDTH-1:0] head;

    // Flags come from the registered count; no pass-through when full.
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign count     = count_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    assign head  = empty ? '0 : mem[rp];
    assign out_a = head[2*WIDTH-1:WIDTH];
    assign out_b = head[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wp      <= '0;
            rp      <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wp <= wp + AW'(1);
            end
            if (pop) begin
                rp <= rp + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Storage is never reset; stale entries are hidden by the empty-forces-zero read.
    always_ff @(posedge clk) begin
        if (push && !reset && !flush) begin
            mem[wp] <= {in_a, in_b};
        end
    end

endmodule

// File: doc/mac_operand_fifo.md
# mac_operand_fifo

Parametrised operand staging buffer for the MAC datapath. It replaces the single-entry, load-enabled A/B input registers with a DEPTH-entry FIFO of (A, B) operand pairs, with valid/ready handshakes on both sides. The MAC core can therefore stall without the upstream source dropping operands, and operand width is no longer fixed at 8 bits. It sits between the operand source (testbench or memory reader) and the multiply-accumulate stage.

## Interface
Parameters:
- WIDTH, 8, bit width of each operand A and B (≥1)
- DEPTH, 4, number of operand-pair entries (power of two, ≥2)
- CW = $clog2(DEPTH)+1 (derived, not overridable), width of the occupancy count

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous clear of FIFO contents, active-high
- in_valid  in  1  upstream presents an operand pair
- in_ready  out  1  FIFO can accept a pair this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- out_valid  out  1  head entry available to MAC
- out_ready  in  1  MAC consumes head entry this cycle
- out_a  out  WIDTH  head operand A
- out_b  out  WIDTH  head operand B
- count  out  CW  current number of stored pairs, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0

## Operation
- Storage: DEPTH × (2·WIDTH) array, write pointer wp, read pointer rp, each $clog2(DEPTH) bits and wrapping modulo DEPTH; count register CW bits.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = !full. There is no pass-through when full: a simultaneous pop does not free a slot in the same cycle.
- out_valid = !empty.
- out_a/out_b: combinational read of entry rp when !empty; forced to 0 when empty, so a stalled MAC sees zero operands, matching the old register clear value.
- push: entry[wp] ← {in_a, in_b}, wp ← wp+1.
- pop: rp ← rp+1.
- count: +1 on push only, −1 on pop only, unchanged on both or neither.
- Both ports are handshake-safe. Data in_a/in_b are ignored when in_valid=0. Holding in_valid while in_ready=0 stalls without loss.
- flush: wp, rp, count ← 0. Any push/pop in the same cycle is discarded. Array contents are not cleared.
- Priority: reset > flush > push/pop.
- Full/empty flags derive from count, not from pointer comparison.

## Timing
- Reset values: in_ready=1, out_valid=0, out_a=0, out_b=0, count=0, full=0, empty=1. Pointers are 0. Array contents are don't-care and are never visible, because output is forced to 0 when empty.
- Latency: a pair pushed at edge N is visible on out_a/out_b with out_valid=1 after edge N; there is 1-cycle latency and no same-cycle bypass when empty.
- Push into an empty FIFO with out_ready=1 in the same cycle: no pop, since out_valid=0.
- Full with push attempt and pop: pop only; count becomes DEPTH−1; in_ready rises the next cycle.
- Wrap: pointer DEPTH−1 → 0 with no bubble; sustained push+pop at 1 pair/cycle holds count constant.
- Reset or flush mid-stream: takes effect at that edge. The next cycle shows the reset values above. Entries in flight are lost by design.
- count/full/empty/in_ready/out_valid all change only on clock edges, driven from registered state.

## Test plan
- Reset check: assert reset 2 cycles with in_valid=1, in_a=8'hAA → count=0, empty=1, out_valid=0, out_a=out_b=0, in_ready=1 after release.
- Fill/drain order (DEPTH=4): push pairs (1,2),(3,4),(5,6),(7,8) with out_ready=0 → full=1, in_ready=0, count=4. A 5th push (9,10) is held. Then out_ready=1 → pops (1,2),(3,4),(5,6),(7,8), then (9,10), in order.
- Streaming wrap: push and pop every cycle for 10 pairs (A=k, B=255−k) after one priming push → count stays 1, outputs match in order across 2 pointer wraps.
- Full + simultaneous pop: at count=4, in_valid=1 and out_ready=1 → only a pop; count=3; in_ready=1 next cycle; the pending pair is accepted then.
- Flush mid-stream: count=3, assert flush with in_valid=1 and out_ready=1 → next cycle count=0, out_valid=0, out_a=0. A subsequent push (8'h11, 8'h22) appears as the head.
- Width/depth param: WIDTH=16, DEPTH=8; push 16'hFFFF/16'h8001 ×8 → full at count=8 (CW=4). Data is popped intact with no truncation.
